// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory FSM that drives
// register-block write enables, source selects, ALU op and a req/ready memory handshake.
module control_sequencer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        comp_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic [1:0]  mary_src,
    output logic [1:0]  shelley_src,
    output logic        ra_src,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_CMP  = 4'h2,
        OP_LIM  = 4'h3,
        OP_LIS  = 4'h4,
        OP_LW   = 4'h5,
        OP_SW   = 4'h6,
        OP_MSH  = 4'h7,
        OP_SMV  = 4'h8,
        OP_JAL  = 4'h9,
        OP_JR   = 4'hA,
        OP_BEQZ = 4'hB,
        OP_ILLC = 4'hC,
        OP_ILLD = 4'hD,
        OP_ILLE = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    state_t      state_q, state_d;
    opcode_t     op_q, op_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic        timeout;

    // Only the opcode field steers the sequencer; operand bits go to the datapath.
    logic unused_operand_bits;
    assign unused_operand_bits = ^instr[11:0];

    assign timeout = (wait_cnt_q == 4'(WAIT_LIMIT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            op_q       <= OP_ADD;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_cnt_d    = wait_cnt_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        alu_op        = 2'b00;
        mary_write    = 1'b0;
        shelley_write = 1'b0;
        comp_write    = 1'b0;
        ra_write      = 1'b0;
        mary_src      = 2'b00;
        shelley_src   = 2'b00;
        ra_src        = 1'b0;

        // Every strobe is forced low while reset is held, even mid-request.
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        op_d       = opcode_t'(instr[15:12]);
                        wait_cnt_d = '0;
                        state_d    = S_DECODE;
                    end else if (timeout) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end

                S_DECODE: begin
                    wait_cnt_d = '0;
                    state_d    = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_EXEC;
                end

                S_EXEC: begin
                    state_d = S_FETCH;
                    case (op_q)
                        OP_ADD: begin
                            alu_op = 2'b00; mary_src = 2'b01; mary_write = 1'b1;
                        end
                        OP_SUB: begin
                            alu_op = 2'b01; mary_src = 2'b01; mary_write = 1'b1;
                        end
                        OP_CMP: begin
                            alu_op = 2'b01; comp_write = 1'b1;
                        end
                        OP_LIM: begin
                            mary_src = 2'b11; mary_write = 1'b1;
                        end
                        OP_LIS: begin
                            shelley_src = 2'b01; shelley_write = 1'b1;
                        end
                        OP_MSH: begin
                            shelley_src = 2'b10; shelley_write = 1'b1;
                        end
                        OP_SMV: begin
                            mary_src = 2'b10; mary_write = 1'b1;
                        end
                        OP_JAL: begin
                            ra_src = 1'b1; ra_write = 1'b1;
                            pc_src = 2'b01; pc_write = 1'b1;
                        end
                        OP_JR: begin
                            pc_src = 2'b10; pc_write = 1'b1;
                        end
                        OP_BEQZ: begin
                            if (comp_zero) begin
                                pc_src = 2'b01; pc_write = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: begin
                            fault_d  = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                    endcase
                end

                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op_q == OP_SW);
                    if (mem_ready) begin
                        if (op_q == OP_LW) begin
                            mary_src   = 2'b00;
                            mary_write = 1'b1;
                        end
                        wait_cnt_d = '0;
                        state_d    = S_FETCH;
                    end else if (timeout) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end

                S_HALT: begin
                    state_d = S_HALT;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign halted = halted_q & reset;
    assign fault  = fault_q & reset;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized instruction stream expanded into expected per-cycle output vectors
// from the instruction timing rules, replayed against control_sequencer.
module tb_control_sequencer;

    localparam int WL = 5;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       mary_write;
        logic       shelley_write;
        logic       comp_write;
        logic       ra_write;
        logic [1:0] mary_src;
        logic [1:0] shelley_src;
        logic       ra_src;
        logic       halted;
        logic       fault;
    } outs_t;

    typedef struct {
        string       tag;
        logic        rst_n;
        logic        rdy;
        logic [15:0] ins;
        logic        cz;
        outs_t       exp;
    } cyc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        comp_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_op, mary_src, shelley_src;
    logic        mary_write, shelley_write, comp_write, ra_write, ra_src, halted, fault;

    int n_tests = 0;
    int n_fail  = 0;
    cyc_t q[$];

    always #5 clock = ~clock;

    control_sequencer #(.WAIT_LIMIT(WL)) dut (
        .clock(clock), .reset(reset), .instr(instr), .comp_zero(comp_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
        .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
        .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src),
        .ra_src(ra_src), .halted(halted), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rword();
        return 16'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic rdy, input logic [15:0] ins,
                        input logic cz, input outs_t e);
        cyc_t c;
        c.tag = tag; c.rst_n = 1'b1; c.rdy = rdy; c.ins = ins; c.cz = cz; c.exp = e;
        q.push_back(c);
    endtask

    task automatic push_rst(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.tag = "reset"; c.rst_n = 1'b0; c.rdy = 1'b1; c.ins = rword();
            c.cz = rbit(); c.exp = '0;
            q.push_back(c);
        end
    endtask

    task automatic halted_tail(input logic f);
        outs_t e;
        e = '0; e.halted = 1'b1; e.fault = f;
        for (int i = 0; i < 3; i++) push("halted", rbit(), rword(), rbit(), e);
    endtask

    // A request phase is `waits` idle cycles then one ready cycle; more than WL idle
    // cycles means the request times out on its (WL+1)-th idle cycle.
    task automatic req_phase(input string tag, input int waits, input outs_t base,
                             input outs_t done, input logic [15:0] word, output bit dead);
        dead = 1'b0;
        if (waits > WL) begin
            for (int i = 0; i <= WL; i++) push({tag, "_wait"}, 1'b0, rword(), rbit(), base);
            dead = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) push({tag, "_wait"}, 1'b0, rword(), rbit(), base);
            push({tag, "_done"}, 1'b1, word, rbit(), done);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic cz);
        outs_t b, d, e;
        bit dead;
        logic [15:0] word;
        word = {op, 12'($urandom)};
        b = '0; b.mem_req = 1'b1;
        d = b; d.ir_write = 1'b1; d.pc_write = 1'b1;
        req_phase("fetch", fw, b, d, word, dead);
        if (dead) begin halted_tail(1'b1); return; end
        push("decode", rbit(), rword(), rbit(), '0);
        if (op == 4'h5 || op == 4'h6) begin
            b = '0; b.mem_req = 1'b1; b.addr_sel = 1'b1; b.mem_we = (op == 4'h6);
            d = b;
            if (op == 4'h5) d.mary_write = 1'b1;
            req_phase("mem", mw, b, d, rword(), dead);
            if (dead) halted_tail(1'b1);
            return;
        end
        e = '0;
        case (op)
            4'h0: begin e.alu_op = 2'b00; e.mary_src = 2'b01; e.mary_write = 1'b1; end
            4'h1: begin e.alu_op = 2'b01; e.mary_src = 2'b01; e.mary_write = 1'b1; end
            4'h2: begin e.alu_op = 2'b01; e.comp_write = 1'b1; end
            4'h3: begin e.mary_src = 2'b11; e.mary_write = 1'b1; end
            4'h4: begin e.shelley_src = 2'b01; e.shelley_write = 1'b1; end
            4'h7: begin e.shelley_src = 2'b10; e.shelley_write = 1'b1; end
            4'h8: begin e.mary_src = 2'b10; e.mary_write = 1'b1; end
            4'h9: begin e.ra_src = 1'b1; e.ra_write = 1'b1; e.pc_src = 2'b01; e.pc_write = 1'b1; end
            4'hA: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
            4'hB: if (cz) begin e.pc_src = 2'b01; e.pc_write = 1'b1; end
            default: ;
        endcase
        push("exec", rbit(), rword(), cz, e);
        if (op == 4'hF) halted_tail(1'b0);
        else if (op >= 4'hC) halted_tail(1'b1);
    endtask

    task automatic reset_mid_mem();
        outs_t b, d;
        b = '0; b.mem_req = 1'b1;
        d = b; d.ir_write = 1'b1; d.pc_write = 1'b1;
        push("rm_fetch", 1'b1, 16'h5000, 1'b0, d);
        push("rm_decode", 1'b0, rword(), 1'b0, '0);
        b = '0; b.mem_req = 1'b1; b.addr_sel = 1'b1;
        push("rm_mem", 1'b0, rword(), 1'b0, b);
        push_rst(2);
        b = '0; b.mem_req = 1'b1;
        push("rm_after", 1'b0, rword(), 1'b0, b);
        push_rst(1);
    endtask

    initial begin
        outs_t got;
        cyc_t c;
        int cyc;

        push_rst(2);
        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom_range(0, 11)), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        run_instr(4'h3, 0, 0, 1'b0);
        run_instr(4'h5, 0, 3, 1'b0);
        run_instr(4'h6, 1, WL, 1'b0);
        run_instr(4'h2, 0, 0, 1'b1);
        run_instr(4'hB, 0, 0, 1'b1);
        run_instr(4'h2, 0, 0, 1'b0);
        run_instr(4'hB, 0, 0, 1'b0);
        run_instr(4'h9, 0, 0, 1'b0);
        run_instr(4'h0, WL, 0, 1'b0);
        run_instr(4'h0, WL + 1, 0, 1'b0);
        push_rst(1);
        run_instr(4'h5, 0, WL + 1, 1'b0);
        push_rst(1);
        run_instr(4'hC, 0, 0, 1'b0);
        push_rst(1);
        run_instr(4'hE, 2, 0, 1'b0);
        push_rst(1);
        run_instr(4'hF, 0, 0, 1'b0);
        push_rst(1);
        reset_mid_mem();
        run_instr(4'h1, 0, 0, 1'b0);

        cyc = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clock);
            reset = c.rst_n; mem_ready = c.rdy; instr = c.ins; comp_zero = c.cz;
            #1;
            got = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_op,
                   mary_write, shelley_write, comp_write, ra_write, mary_src,
                   shelley_src, ra_src, halted, fault};
            check($sformatf("%s@%0d", c.tag, cyc), 32'(got), 32'(c.exp));
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
